// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// Purpose : tracks outstanding OBI transactions against the PMA verdict that
//           was in force when each address phase was granted. One instance
//           per bus (instruction or data side).
// Ports   : clk/rst               clock, synchronous active-high reset
//           obi_*_i               OBI address phase (req/gnt/addr/memtype)
//                                 and response valid
//           pma_*_i               PMA status for obi_addr_i
//           resp_*_o              registered view of the entry popped by
//                                 the previous cycle's response
//           outstanding_o         FIFO occupancy
//           txn_count_o           saturating count of granted transactions
//           err_pulse_o           one-cycle error pulses
//                                 [0] leaked [1] memtype [2] overflow
//                                 [3] underflow [4] instr_bufferable
//           err_sticky_o          accumulated err_pulse_o, cleared by rst
module uvmt_cv32e40x_pma_obi_tracker #(
  parameter int unsigned DEPTH         = 4,
  parameter bit          IS_INSTR_SIDE = 1'b0,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       obi_req_i,
  input  logic                       obi_gnt_i,
  input  logic [31:0]                obi_addr_i,
  input  logic [1:0]                 obi_memtype_i,
  input  logic                       obi_rvalid_i,
  input  logic                       pma_allow_i,
  input  logic                       pma_bufferable_i,
  input  logic                       pma_cacheable_i,
  output logic                       resp_valid_o,
  output logic [31:0]                resp_addr_o,
  output logic [1:0]                 resp_attr_o,
  output logic [$clog2(DEPTH):0]     outstanding_o,
  output logic [CNT_W-1:0]           txn_count_o,
  output logic [4:0]                 err_pulse_o,
  output logic [4:0]                 err_sticky_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  // The allow verdict is fully consumed by the leaked check at push time,
  // so only the address and expected attributes need to travel with the entry.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  attr;  // {cacheable, bufferable}
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_addr_q, resp_addr_d;
  logic [1:0]         resp_attr_q, resp_attr_d;
  logic [CNT_W-1:0]   txn_q, txn_d;
  logic [4:0]         err_pulse_q, err_pulse_d;
  logic [4:0]         err_sticky_q, err_sticky_d;

  logic push, pop, empty, full, push_ok, pop_ok;

  always_comb begin
    push    = obi_req_i & obi_gnt_i;
    pop     = obi_rvalid_i;
    empty   = (occ_q == '0);
    full    = (occ_q == OCC_W'(DEPTH));
    pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    push_ok = push & (~full | pop_ok);

    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    occ_d        = occ_q;
    resp_valid_d = pop_ok;
    resp_addr_d  = resp_addr_q;
    resp_attr_d  = resp_attr_q;
    txn_d        = txn_q;

    if (push_ok) begin
      mem_d[wptr_q] = '{addr: obi_addr_i, attr: {pma_cacheable_i, pma_bufferable_i}};
      wptr_d        = wptr_q + PTR_W'(1);
    end

    if (pop_ok) begin
      resp_addr_d = mem_q[rptr_q].addr;
      resp_attr_d = mem_q[rptr_q].attr;
      rptr_d      = rptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (push && (txn_q != '1)) begin
      txn_d = txn_q + CNT_W'(1);
    end

    err_pulse_d[0] = push & ~pma_allow_i;
    err_pulse_d[1] = push & (obi_memtype_i != {pma_cacheable_i, pma_bufferable_i});
    err_pulse_d[2] = push & full & ~pop;
    err_pulse_d[3] = pop & empty;
    err_pulse_d[4] = push & IS_INSTR_SIDE & obi_memtype_i[0];

    // Sticky follows the pulse in the same cycle it becomes visible.
    err_sticky_d = err_sticky_q | err_pulse_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_attr_q  <= '0;
      txn_q        <= '0;
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      resp_attr_q  <= resp_attr_d;
      txn_q        <= txn_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_addr_o   = resp_addr_q;
  assign resp_attr_o   = resp_attr_q;
  assign outstanding_o = occ_q;
  assign txn_count_o   = txn_q;
  assign err_pulse_o   = err_pulse_q;
  assign err_sticky_o  = err_sticky_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv
module tb_uvmt_cv32e40x_pma_obi_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        obi_req_i, obi_gnt_i, obi_rvalid_i;
  logic [31:0] obi_addr_i;
  logic [1:0]  obi_memtype_i;
  logic        pma_allow_i, pma_bufferable_i, pma_cacheable_i;

  logic        d_resp_valid, i_resp_valid;
  logic [31:0] d_resp_addr, i_resp_addr;
  logic [1:0]  d_resp_attr, i_resp_attr;
  logic [2:0]  d_outstanding, i_outstanding;
  logic [31:0] d_txn;
  logic [2:0]  i_txn;
  logic [4:0]  d_pulse, i_pulse, d_sticky, i_sticky;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Data-side instance with default parameters.
  uvmt_cv32e40x_pma_obi_tracker #(.DEPTH(4), .IS_INSTR_SIDE(1'b0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .obi_req_i(obi_req_i), .obi_gnt_i(obi_gnt_i), .obi_addr_i(obi_addr_i),
    .obi_memtype_i(obi_memtype_i), .obi_rvalid_i(obi_rvalid_i),
    .pma_allow_i(pma_allow_i), .pma_bufferable_i(pma_bufferable_i),
    .pma_cacheable_i(pma_cacheable_i),
    .resp_valid_o(d_resp_valid), .resp_addr_o(d_resp_addr), .resp_attr_o(d_resp_attr),
    .outstanding_o(d_outstanding), .txn_count_o(d_txn),
    .err_pulse_o(d_pulse), .err_sticky_o(d_sticky)
  );

  // Instruction-side instance with a narrow counter to reach saturation.
  uvmt_cv32e40x_pma_obi_tracker #(.DEPTH(4), .IS_INSTR_SIDE(1'b1), .CNT_W(3)) dut_i (
    .clk(clk), .rst(rst),
    .obi_req_i(obi_req_i), .obi_gnt_i(obi_gnt_i), .obi_addr_i(obi_addr_i),
    .obi_memtype_i(obi_memtype_i), .obi_rvalid_i(obi_rvalid_i),
    .pma_allow_i(pma_allow_i), .pma_bufferable_i(pma_bufferable_i),
    .pma_cacheable_i(pma_cacheable_i),
    .resp_valid_o(i_resp_valid), .resp_addr_o(i_resp_addr), .resp_attr_o(i_resp_attr),
    .outstanding_o(i_outstanding), .txn_count_o(i_txn),
    .err_pulse_o(i_pulse), .err_sticky_o(i_sticky)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic gnt, input logic [31:0] addr,
                       input logic [1:0] mt, input logic rv, input logic allow,
                       input logic c, input logic b);
    obi_req_i        = req;
    obi_gnt_i        = gnt;
    obi_addr_i       = addr;
    obi_memtype_i    = mt;
    obi_rvalid_i     = rv;
    pma_allow_i      = allow;
    pma_cacheable_i  = c;
    pma_bufferable_i = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [31:0] exp_addr [4];
  logic [1:0]  exp_attr [4];

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) step();
    chk_val("rst_valid", {31'b0, d_resp_valid}, 32'd0);
    chk_val("rst_outst", {29'b0, d_outstanding}, 32'd0);
    chk_val("rst_txn", d_txn, 32'd0);
    chk_val("rst_sticky", {27'b0, d_sticky}, 32'd0);
    rst = 1'b0;

    // Single access
    drive(1'b1, 1'b1, 32'h0000_1000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_val("t1_outst1", {29'b0, d_outstanding}, 32'd1);
    idle();
    step();
    // req without gnt changes nothing
    drive(1'b1, 1'b0, 32'h0000_DEAD, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_val("t1_nognt_txn", d_txn, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_val("t1_outst0", {29'b0, d_outstanding}, 32'd0);
    chk_val("t1_valid", {31'b0, d_resp_valid}, 32'd1);
    chk_val("t1_addr", d_resp_addr, 32'h0000_1000);
    idle();
    step();
    chk_val("t1_valid_drop", {31'b0, d_resp_valid}, 32'd0);
    chk_val("t1_addr_hold", d_resp_addr, 32'h0000_1000);
    chk_val("t1_sticky", {27'b0, d_sticky}, 32'd0);

    // Fill to DEPTH with varied attributes, then overflow
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 32'h2000 + 32'(i * 4);
      exp_attr[i] = 2'(i);
      drive(1'b1, 1'b1, exp_addr[i], exp_attr[i], 1'b0, 1'b1, exp_attr[i][1], exp_attr[i][0]);
      step();
    end
    chk_val("t2_outst4", {29'b0, d_outstanding}, 32'd4);
    drive(1'b1, 1'b1, 32'h0000_2010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_val("t2_ovf_pulse", {27'b0, d_pulse}, 32'b00100);
    chk_val("t2_outst_ovf", {29'b0, d_outstanding}, 32'd4);
    chk_val("t2_txn", d_txn, 32'd6);
    idle();
    step();
    chk_val("t2_pulse_clr", {27'b0, d_pulse}, 32'd0);
    chk_val("t2_sticky", {27'b0, d_sticky}, 32'b00100);

    // Push + pop at full; order preserved across pointer wrap
    drive(1'b1, 1'b1, 32'h0000_3000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk_val("t3_no_ovf", {27'b0, d_pulse}, 32'd0);
    chk_val("t3_outst4", {29'b0, d_outstanding}, 32'd4);
    chk_val("t3_addr0", d_resp_addr, 32'h0000_2000);
    chk_val("t3_attr0", {30'b0, d_resp_attr}, 32'b00);
    exp_addr[0] = 32'h0000_3000;
    exp_attr[0] = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk_val($sformatf("t3_addr%0d", i), d_resp_addr, exp_addr[i % 4]);
      chk_val($sformatf("t3_attr%0d", i), {30'b0, d_resp_attr}, {30'b0, exp_attr[i % 4]});
    end
    idle();
    step();
    chk_val("t3_outst0", {29'b0, d_outstanding}, 32'd0);
    chk_val("t3_txn", d_txn, 32'd7);

    // Leaked + memtype in one push
    drive(1'b1, 1'b1, 32'h0000_4000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_val("t4_pulse", {27'b0, d_pulse}, 32'b00011);
    chk_val("t4_pulse_i", {27'b0, i_pulse}, 32'b10011);
    idle();
    step();
    chk_val("t4_pulse_clr", {27'b0, d_pulse}, 32'd0);
    repeat (9) step();
    chk_val("t4_sticky", {27'b0, d_sticky}, 32'b00111);
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_val("t4_pop_addr", d_resp_addr, 32'h0000_4000);
    chk_val("t4_outst0", {29'b0, d_outstanding}, 32'd0);

    // Underflow with simultaneous push
    drive(1'b1, 1'b1, 32'h0000_5000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_val("t5_unf_pulse", {27'b0, d_pulse}, 32'b01000);
    chk_val("t5_outst1", {29'b0, d_outstanding}, 32'd1);
    chk_val("t5_valid", {31'b0, d_resp_valid}, 32'd0);
    chk_val("t5_txn", d_txn, 32'd9);
    chk_val("t5_txn_sat_i", {29'b0, i_txn}, 32'd7);

    // Instruction side: bufferable without memtype mismatch, then reset mid-flight
    drive(1'b1, 1'b1, 32'h0000_6000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk_val("t6_pulse_i", {27'b0, i_pulse}, 32'b10000);
    chk_val("t6_pulse_d", {27'b0, d_pulse}, 32'd0);
    chk_val("t6_outst2", {29'b0, i_outstanding}, 32'd2);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_val("t6_rst_outst", {29'b0, i_outstanding}, 32'd0);
    chk_val("t6_rst_txn", {29'b0, i_txn}, 32'd0);
    chk_val("t6_rst_sticky", {27'b0, i_sticky}, 32'd0);
    chk_val("t6_rst_pulse", {27'b0, i_pulse}, 32'd0);
    chk_val("t6_rst_addr", i_resp_addr, 32'd0);
    chk_val("t6_rst_dsticky", {27'b0, d_sticky}, 32'd0);
    step();
    chk_val("t6_post_sticky", {27'b0, i_sticky}, 32'd0);
    chk_val("t6_post_outst", {29'b0, d_outstanding}, 32'd0);

    // Pointers restart from zero after reset
    drive(1'b1, 1'b1, 32'h0000_7000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_val("t7_addr", d_resp_addr, 32'h0000_7000);
    chk_val("t7_attr", {30'b0, d_resp_attr}, 32'b10);
    chk_val("t7_txn", d_txn, 32'd1);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
